// File: rtl/fmul_round.sv
// fmul_round: normalise, round and pack a raw FP product into IEEE-754 with a 2-stage valid/ready pipe.
// Define FMUL_ROUND_FLAGS_EN to compute fflags_o; otherwise fflags_o is tied to zero.
module fmul_round #(
  parameter int FW = 23,
  parameter int EW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [EW+1:0]   exponent_i,
  input  logic [2*FW+1:0] significant_i,
  input  logic            sign_i,
  input  logic            inf_i,
  input  logic            nan_i,
  input  logic            zero_i,
  input  logic            invalid_i,
  input  logic [2:0]      rm_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [EW+FW:0]  result_o,
  output logic [4:0]      fflags_o
);
  localparam int SW = 2*FW+2;
  localparam int XW = EW+2;
  localparam logic [2:0] RTZ = 3'b001, RDN = 3'b010, RUP = 3'b011, RMM = 3'b100;
  localparam logic [XW:0] MAXE = (XW+1)'((1 << EW) - 1);

  typedef struct packed {
    logic          sign;
    logic [XW-1:0] exp;
    logic [FW:0]   kept;
    logic          guard;
    logic          sticky;
    logic          inf;
    logic          nan;
    logic          zero;
    logic [2:0]    rm;
`ifdef FMUL_ROUND_FLAGS_EN
    logic          invalid;
`endif
  } s1_t;

  logic [2:1]    vldPipe;
  logic          adv1;
  s1_t           s1, s1Next;
  logic [4:0]    flagsNext;
  logic [EW+FW:0] resNext;

  assign adv1    = ~vldPipe[2] | ready_i;
  assign ready_o = ~vldPipe[1] | adv1;
  assign valid_o = vldPipe[2];

  // Stage 1: normalise; left shift never drops the exponent below 1, subnormals shift right into sticky.
  int eN, lz, lsh, rsh;
  logic [SW-1:0]   sigN;
  logic [2*SW-1:0] wide;
  always_comb begin
    s1Next = '0;
    eN = int'($signed(exponent_i));
    lz = SW;
    for (int i = 0; i < SW; i++)
      if (significant_i[i]) lz = SW-1-i;
    lsh = 0;
    if (!significant_i[SW-1] && !zero_i && eN > 1)
      lsh = (lz < eN-1) ? lz : eN-1;
    sigN = significant_i << lsh;
    eN = eN - lsh;
    rsh = 0;
    if (eN <= 0) begin
      rsh = (1-eN > SW+1) ? SW+1 : 1-eN;
      eN = 0;
    end
    wide = {sigN, {SW{1'b0}}} >> rsh;
    s1Next.sign   = sign_i;
    s1Next.kept   = wide[2*SW-1 -: FW+1];
    s1Next.guard  = wide[2*SW-FW-2];
    s1Next.sticky = |wide[2*SW-FW-3:0];
    // An unnormalised significand at exponent 1 is really a subnormal.
    s1Next.exp    = s1Next.kept[FW] ? XW'(eN) : '0;
    s1Next.inf    = inf_i;
    s1Next.nan    = nan_i;
    s1Next.zero   = zero_i;
    s1Next.rm     = rm_i;
`ifdef FMUL_ROUND_FLAGS_EN
    s1Next.invalid = invalid_i;
`endif
  end

  // Stage 2: round, renormalise on carry, saturate, and apply specials.
  logic          inc, ovf, toInf;
  logic [FW+1:0] sum;
  logic [FW-1:0] mant;
  logic [XW:0]   rExp;
  always_comb begin
    case (s1.rm)
      RTZ:     inc = 1'b0;
      RDN:     inc = s1.sign & (s1.guard | s1.sticky);
      RUP:     inc = ~s1.sign & (s1.guard | s1.sticky);
      RMM:     inc = s1.guard;
      default: inc = s1.guard & (s1.sticky | s1.kept[0]);
    endcase
    sum  = {1'b0, s1.kept} + {{(FW+1){1'b0}}, inc};
    mant = sum[FW-1:0];
    rExp = {1'b0, s1.exp};
    if (sum[FW+1]) begin
      mant = sum[FW:1];
      rExp = rExp + (XW+1)'(1);
    end else if (rExp == '0 && sum[FW]) begin
      rExp = (XW+1)'(1);
    end
    ovf   = rExp >= MAXE;
    toInf = (s1.rm == RUP) ? ~s1.sign : (s1.rm == RDN) ? s1.sign : (s1.rm != RTZ);
    if (s1.nan)       resNext = {1'b0, {EW{1'b1}}, 1'b1, {(FW-1){1'b0}}};
    else if (s1.inf)  resNext = {s1.sign, {EW{1'b1}}, {FW{1'b0}}};
    else if (s1.zero) resNext = {s1.sign, {(EW+FW){1'b0}}};
    else if (ovf)     resNext = toInf ? {s1.sign, {EW{1'b1}}, {FW{1'b0}}}
                                      : {s1.sign, {(EW-1){1'b1}}, 1'b0, {FW{1'b1}}};
    else              resNext = {s1.sign, rExp[EW-1:0], mant};
  end

`ifdef FMUL_ROUND_FLAGS_EN
  logic nx;
  always_comb begin
    nx = s1.guard | s1.sticky | ovf;
    flagsNext = {s1.invalid, 1'b0, ovf, (rExp == '0) & nx, nx};
    if (s1.nan | s1.inf | s1.zero) flagsNext = {s1.invalid, 4'b0};
  end
`else
  logic unusedInvalid;
  assign unusedInvalid = invalid_i;
  assign flagsNext = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vldPipe  <= '0;
      s1       <= '0;
      result_o <= '0;
      fflags_o <= '0;
    end else begin
      if (ready_o) vldPipe[1] <= valid_i;
      if (valid_i && ready_o) s1 <= s1Next;
      if (adv1) begin
        vldPipe[2] <= vldPipe[1];
        if (vldPipe[1]) begin
          result_o <= resNext;
          fflags_o <= flagsNext;
        end
      end
    end
  end
endmodule

// File: tb/tb_fmul_round.sv
// Bench for fmul_round: directed corner vectors plus randomized traffic scored against an exact-arithmetic model.
module tb_fmul_round;
  logic        clk, rst_n, valid_i, ready_o, sign_i, inf_i, nan_i, zero_i, invalid_i;
  logic [9:0]  exponent_i;
  logic [47:0] significant_i;
  logic [2:0]  rm_i;
  logic        valid_o, ready_i;
  logic [31:0] result_o;
  logic [4:0]  fflags_o;

  fmul_round dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .exponent_i(exponent_i), .significant_i(significant_i), .sign_i(sign_i),
    .inf_i(inf_i), .nan_i(nan_i), .zero_i(zero_i), .invalid_i(invalid_i), .rm_i(rm_i),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o), .fflags_o(fflags_o)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  e;
    logic [47:0] sig;
    logic sgn, inf, nan, zero, inv;
    logic [2:0]  rm;
  } item_t;

  int nChecks = 0, nErrors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] maskFl(input logic [4:0] fl);
`ifdef FMUL_ROUND_FLAGS_EN
    return fl;
`else
    return 5'b0;
`endif
  endfunction

  // Value = sig * 2^(e-127-47); quantise to the ulp of the target exponent, then round.
  function automatic logic [36:0] refModel(input item_t it);
    int ex, p, b, sh, fieldE;
    longint unsigned m, kept;
    bit g, s, inc, nx, toInf;
    logic [31:0] res;
    logic [4:0]  fl;
    if (it.nan)  return {32'h7FC00000, it.inv, 4'b0};
    if (it.inf)  return {it.sgn, 8'hFF, 23'b0, it.inv, 4'b0};
    if (it.zero) return {it.sgn, 31'b0, it.inv, 4'b0};
    ex = int'($signed(it.e));
    m = {16'b0, it.sig};
    g = 0; s = 0; kept = 0; b = 1;
    if (m != 0) begin
      p = 0;
      for (int i = 0; i < 48; i++) if (it.sig[i]) p = i;
      b = p + ex - 47;
      if (b < 1) b = 1;
      sh = ex - 24 - b;
      if (sh >= 0) kept = m << sh;
      else if (-sh > 48) begin kept = 0; s = 1; end
      else begin
        kept = m >> (-sh);
        g = m[-sh-1];
        s = (m & ((64'd1 << (-sh-1)) - 64'd1)) != 0;
      end
    end
    case (it.rm)
      3'd1: inc = 0;
      3'd2: inc = it.sgn & (g | s);
      3'd3: inc = !it.sgn & (g | s);
      3'd4: inc = g;
      default: inc = g & (s | kept[0]);
    endcase
    kept = kept + {63'b0, inc};
    if (kept == 64'h100_0000) begin kept = 64'h80_0000; b++; end
    fieldE = (kept >= 64'h80_0000) ? b : 0;
    nx = g | s;
    if (fieldE >= 255) begin
      toInf = (it.rm == 3'd3) ? !it.sgn : (it.rm == 3'd2) ? it.sgn : (it.rm != 3'd1);
      res = toInf ? {it.sgn, 8'hFF, 23'h0} : {it.sgn, 8'hFE, 23'h7FFFFF};
      fl = {it.inv, 4'b0101};
    end else begin
      res = {it.sgn, fieldE[7:0], kept[22:0]};
      fl = {it.inv, 1'b0, 1'b0, (fieldE == 0) && nx, nx};
    end
    return {res, fl};
  endfunction

  task automatic apply(input item_t it);
    exponent_i = it.e; significant_i = it.sig; sign_i = it.sgn; inf_i = it.inf;
    nan_i = it.nan; zero_i = it.zero; invalid_i = it.inv; rm_i = it.rm; valid_i = 1;
  endtask

  function automatic item_t randItem();
    item_t it;
    int ev;
    logic [63:0] r;
    r = {$urandom, $urandom};
    it.sig = r[47:0];
    case ($urandom_range(3))
      0: it.sig[47] = 1'b1;
      1: it.sig = it.sig >> $urandom_range(47);
      2: begin it.sig[47] = 1'b1; it.sig[22:0] = '0; end
      default: ;
    endcase
    case ($urandom_range(5))
      0: ev = 107 + int'($urandom_range(40));
      1: ev = -30 + int'($urandom_range(35));
      2: ev = 240 + int'($urandom_range(30));
      3: ev = int'($urandom_range(1023)) - 512;
      default: ev = 100 + int'($urandom_range(50));
    endcase
    it.e    = 10'(ev);
    it.sgn  = 1'($urandom_range(1));
    it.nan  = $urandom_range(15) == 0;
    it.inf  = $urandom_range(15) == 0;
    it.zero = $urandom_range(15) == 0;
    it.inv  = it.nan & 1'($urandom_range(1));
    it.rm   = 3'($urandom_range(7));
    return it;
  endfunction

  // Scoreboard: record every accepted item, compare every delivered result in order.
  logic [36:0] expQ[$];
  logic [36:0] expV;
  item_t cur;
  always @(negedge clk) begin
    if (!rst_n) expQ.delete();
    else begin
      if (valid_o && ready_i) begin
        if (expQ.size() == 0) check("spurious_out", 64'(valid_o), 64'(0));
        else begin
          expV = expQ.pop_front();
          check("sb_res", 64'(result_o), 64'(expV[36:5]));
          check("sb_flg", 64'(fflags_o), 64'(maskFl(expV[4:0])));
        end
      end
      if (valid_i && ready_o) begin
        cur = '{exponent_i, significant_i, sign_i, inf_i, nan_i, zero_i, invalid_i, rm_i};
        expQ.push_back(refModel(cur));
      end
    end
  end

  task automatic runDir(input string tag, input logic [9:0] e, input logic [47:0] sig,
                        input logic sgn, input logic inf, input logic nan, input logic zero,
                        input logic inv, input logic [2:0] rm, input logic [31:0] res,
                        input logic [4:0] fl);
    item_t it;
    int lat;
    it = '{e, sig, sgn, inf, nan, zero, inv, rm};
    ready_i = 1;
    apply(it);
    @(posedge clk); #1;
    valid_i = 0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!valid_o && lat < 8);
    check({tag, "_lat"}, 64'(lat), 64'(2));
    check({tag, "_res"}, 64'(result_o), 64'(res));
    check({tag, "_flg"}, 64'(fflags_o), 64'(maskFl(fl)));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    item_t a, b, c;
    logic [36:0] expA;
    int n, stale;
    bit acc;
    rst_n = 0; valid_i = 0; ready_i = 0;
    exponent_i = '0; significant_i = '0; sign_i = 0; inf_i = 0; nan_i = 0;
    zero_i = 0; invalid_i = 0; rm_i = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    check("rst_valid", 64'(valid_o), 64'(0));
    check("rst_result", 64'(result_o), 64'(0));
    check("rst_flags", 64'(fflags_o), 64'(0));
    check("rst_ready", 64'(ready_o), 64'(1));
    @(posedge clk); #1;

    runDir("carry",    10'd128, 48'h9000_0000_0000, 0,0,0,0,0, 3'd0, 32'h40100000, 5'h00);
    runDir("tie_odd",  10'd127, 48'h800001_800000,  0,0,0,0,0, 3'd0, 32'h3F800002, 5'h01);
    runDir("tie_even", 10'd127, 48'h800000_800000,  0,0,0,0,0, 3'd0, 32'h3F800000, 5'h01);
    runDir("ovf_rne",  10'd255, 48'h8000_0000_0000, 0,0,0,0,0, 3'd0, 32'h7F800000, 5'h05);
    runDir("ovf_rtz",  10'd255, 48'h8000_0000_0000, 0,0,0,0,0, 3'd1, 32'h7F7FFFFF, 5'h05);
    runDir("sub",      10'd0,   48'h8000_0000_0000, 0,0,0,0,0, 3'd0, 32'h00400000, 5'h00);
    runDir("sub_nx",   10'd0,   48'h8000_0000_0001, 0,0,0,0,0, 3'd0, 32'h00400000, 5'h03);
    runDir("nan",      10'd5,   48'h1234_5678_9ABC, 1,0,1,0,1, 3'd0, 32'h7FC00000, 5'h10);
    runDir("inf",      10'd5,   48'h0,              1,1,0,0,0, 3'd0, 32'hFF800000, 5'h00);
    runDir("zero",     10'd90,  48'hC000_0000_0000, 1,0,0,1,0, 3'd0, 32'h80000000, 5'h00);
    runDir("rup",      10'd127, 48'h800000_000001,  0,0,0,0,0, 3'd3, 32'h3F800001, 5'h01);
    runDir("rdn_neg",  10'd127, 48'h800000_000001,  1,0,0,0,0, 3'd2, 32'hBF800001, 5'h01);
    runDir("rnd_carry",10'd127, 48'hFFFFFF_800000,  0,0,0,0,0, 3'd0, 32'h40000000, 5'h01);
    runDir("sub_to_n", 10'd0,   48'hFFFF_FFFF_FFFF, 0,0,0,0,0, 3'd0, 32'h00800000, 5'h01);
    runDir("lzc",      10'd130, 48'h2000_0000_0000, 0,0,0,0,0, 3'd0, 32'h40000000, 5'h00);

    // Backpressure: third item must stall, outputs hold the first result.
    ready_i = 0;
    a = randItem(); a.nan = 0; a.inf = 0; a.zero = 0;
    b = randItem(); c = randItem();
    expA = refModel(a);
    apply(a); @(posedge clk); #1;
    apply(b); @(posedge clk); #1;
    apply(c);
    @(negedge clk);
    check("bp_ready", 64'(ready_o), 64'(0));
    repeat (3) begin
      check("bp_valid", 64'(valid_o), 64'(1));
      check("bp_hold", 64'(result_o), 64'(expA[36:5]));
      @(negedge clk);
    end
    @(posedge clk); #1;
    ready_i = 1;
    n = 0;
    do begin
      @(negedge clk); acc = ready_o; n++;
      @(posedge clk); #1;
    end while (!acc && n < 5);
    check("bp_accept", 64'(acc), 64'(1));
    valid_i = 0;

    // Random traffic with random backpressure; inputs hold until accepted.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk); acc = valid_i && ready_o;
      @(posedge clk); #1;
      if (acc || !valid_i) begin
        if ($urandom_range(3) != 0) apply(randItem());
        else valid_i = 0;
      end
      ready_i = $urandom_range(3) != 0;
    end
    valid_i = 0; ready_i = 1;
    n = 0;
    while (expQ.size() != 0 && n < 50) begin @(negedge clk); n++; end
    check("rand_drain", 64'(expQ.size()), 64'(0));

    // Reset while the pipe is full: nothing stale may come out afterwards.
    @(posedge clk); #1;
    ready_i = 0;
    repeat (3) begin apply(randItem()); @(posedge clk); #1; end
    rst_n = 0; valid_i = 0;
    @(posedge clk); #1;
    rst_n = 1; ready_i = 1;
    @(negedge clk);
    check("midrst_valid", 64'(valid_o), 64'(0));
    check("midrst_result", 64'(result_o), 64'(0));
    check("midrst_ready", 64'(ready_o), 64'(1));
    stale = 0;
    repeat (6) begin @(negedge clk); if (valid_o) stale++; end
    check("midrst_stale", 64'(stale), 64'(0));

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end
endmodule

// File: doc/fmul_round.md
Name: fmul_round

Overview:
- Post-multiply normalise/round/pack stage. Sits directly downstream of the FP multiplier core.
- Consumes the registered raw product: an (EW+2)-bit biased exponent and a 2FW+2-bit significand, plus special-case flags.
- Produces an IEEE-754 packed result and RISC-V fflags through a 2-stage valid/ready pipeline.
- Instantiated once per vector FP lane.

Parameters:
- FW, 23, fraction width (hidden bit excluded).
- EW, 8, exponent width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- valid_i  in  1  product valid.
- ready_o  out  1  stage can accept.
- exponent_i  in  EW+2  biased exponent, two's complement; may be negative or ≥2^EW-1.
- significant_i  in  2FW+2  product significand; bit 2FW+1 is the integer bit.
- sign_i  in  1  result sign.
- inf_i  in  1  infinite result.
- nan_i  in  1  NaN result.
- zero_i  in  1  zero result.
- invalid_i  in  1  invalid operation (sNaN operand or 0×inf), from unpack stage.
- rm_i  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101–111 behave as RNE.
- valid_o  out  1  result valid.
- ready_i  in  1  consumer ready.
- result_o  out  1+EW+FW  packed {sign, exp, frac}.
- fflags_o  out  5  {NV, DZ, OF, UF, NX}.

Behaviour:
- Reset (rst_n=0 at posedge): both stage valids clear → valid_o=0, result_o=0, fflags_o=0. Any in-flight data is discarded. ready_o=1 in the cycle after reset.
- Handshake:
  - Transfer in when valid_i & ready_o; out when valid_o & ready_i.
  - ready_o = ~s1_valid | adv1, where adv1 = ~s2_valid | ready_i. ready_o is combinational from ready_i; no skid buffer.
  - Latency: accept at cycle N → valid_o at N+2 if unstalled. Throughput 1/cycle.
  - Stall (ready_i=0, s2 full): s2 and s1 hold data; s1 accepts only if empty. Order is preserved.
  - The data path must be stable while valid_o=1 & ready_i=0.
- Stage 1, normalise:
  - If integer bit = 0 and ~zero_i: left-shift by leading-zero count. Decrement the exponent accordingly, but never below 1 (shift is limited).
  - If the exponent is then ≤ 0: right-shift by 1−exp, clamped at 2FW+3. Shifted-out bits OR into sticky. Exponent becomes 0 (subnormal).
  - Register {sign, exp, significand top FW+1 bits, guard, sticky, specials, rm, invalid}.
- Stage 2, round and pack:
  - Increment rule:
    - RNE: G&(S|L).
    - RTZ: 0.
    - RDN: sign&(G|S).
    - RUP: ~sign&(G|S).
    - RMM: G.
    - L = kept LSB.
  - Mantissa carry out renormalises (shift right 1, exp+1). A subnormal rounding into the hidden bit becomes exp=1.
  - Overflow when the post-round exponent is ≥ 2^EW−1. Result is inf if RNE/RMM, RUP with +, or RDN with −; otherwise max finite. Sets OF|NX.
  - UF = tiny after rounding (exp 0) & NX. NX = (G|S) | OF.
  - Special-case priority: nan_i > inf_i > zero_i > normal path.
    - nan_i: canonical NaN (sign 0, exp all ones, frac MSB 1, rest 0). OF/UF/NX = 0.
    - inf_i: signed inf, no flags.
    - zero_i: signed zero, no flags.
  - NV = invalid_i. DZ always 0.

Optional Feature:
- Macro: FMUL_ROUND_FLAGS_EN.
- Defined: fflags_o computed as above.
- Undefined: fflags_o tied to 0, and invalid_i and the flag logic are unused. Results are identical either way.

Test Plan:
- Normal product, carry case: exponent_i=128, significant_i=48'h9000_0000_0000, sign 0, RNE → result 0x40100000, fflags 0x00, valid_o two cycles after accept.
- RNE ties:
  - Kept 0x800001, G=1, S=0, exp 127 → 0x3F800002, NX (0x01).
  - Kept 0x800000, G=1, S=0 → 0x3F800000, 0x01.
- Overflow: exp=255, sig=48'h8000_0000_0000:
  - RNE → 0x7F800000, fflags 0x05.
  - RTZ → 0x7F7FFFFF, fflags 0x05.
- Subnormal: exp=0, sig=48'h8000_0000_0000, RNE → 0x00400000, fflags 0x00.
  - Same with sig LSB=1 → 0x00400000, fflags 0x03.
- Specials:
  - nan_i=1, invalid_i=1 → 0x7FC00000, 0x10.
  - inf_i=1, sign 1 → 0xFF800000, 0x00.
- Backpressure and reset:
  - Push 3 back-to-back items with ready_i=0: third not accepted (ready_o=0), outputs held stable.
  - Raise ready_i: items emerge in order.
  - Assert rst_n=0 mid-stream: next cycle valid_o=0 and no stale item appears afterwards.
